tdp_bist_ctrl: RTL and testbench

Built-in self-test sequencer for the 10-entry x 256-bit true dual-port RAM; it acts as the initiator on both RAM ports. It writes an address-keyed pattern through port A and reads it back through port B, then writes the complement through port B and reads it back through port A. Every returned word is compared, and the result is reported as pass/fail, a miscompare count and the first failing address. It sits between the test/config logic and the RAM; in test builds, functional traffic is muxed off the RAM ports while `busy`.

---
 rtl/tdp_bist_pkg.sv | 24 ++
 rtl/tdp_bist_cmp.sv | 48 ++++
 rtl/tdp_bist_ctrl.sv | 172 +++++++++++++++++
 tb/tb_tdp_bist_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tdp_bist_pkg.sv
// Shared types and pattern generator for the dual-port RAM BIST sequencer.
package tdp_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_A,
        RD_B,
        WR_B,
        RD_A,
        FIN
    } bist_state_e;

    localparam logic [7:0]  PAT_BYTE  = 8'h55;
    localparam int unsigned PAT_MAX_W = 1024;

    // Widest supported pattern; callers size-cast down to their word width.
    function automatic logic [PAT_MAX_W-1:0] bist_pattern(input logic [15:0] addr,
                                                         input logic        inv);
        logic [PAT_MAX_W-1:0] p;
        p = {(PAT_MAX_W/8){PAT_BYTE}} ^ {{(PAT_MAX_W-16){1'b0}}, addr};
        return inv ? ~p : p;
    endfunction

endpackage

// File: rtl/tdp_bist_cmp.sv
// Read-data checker: registers the expected word/address alongside the RAM
// read latency, then compares the returned word from the active port.
module tdp_bist_cmp
    import tdp_bist_pkg::*;
#(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_vld_i,
    input  logic              rd_phase_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] doutA_i,
    input  logic [DATA_W-1:0] doutB_i,
    output logic              mismatch_o,
    output logic [ADDR_W-1:0] mis_addr_o,
    output logic              mis_phase_o
);

    logic              vld_q;
    logic              phase_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] exp_q;
    logic [DATA_W-1:0] rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= 1'b0;
            phase_q <= 1'b0;
            addr_q  <= '0;
            exp_q   <= '0;
        end else begin
            vld_q   <= rd_vld_i;
            phase_q <= rd_phase_i;
            addr_q  <= rd_addr_i;
            exp_q   <= DATA_W'(bist_pattern(16'(rd_addr_i), rd_phase_i));
        end
    end

    always_comb begin
        rdata       = phase_q ? doutA_i : doutB_i;
        mismatch_o  = vld_q && (rdata != exp_q);
        mis_addr_o  = addr_q;
        mis_phase_o = phase_q;
    end

endmodule

// File: rtl/tdp_bist_ctrl.sv
// BIST sequencer for the true dual-port RAM: write A / read B, then write
// complement on B / read A, reporting pass, miscompare count and first failure.
module tdp_bist_ctrl
    import tdp_bist_pkg::*;
#(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        fail_count,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic              first_fail_phase,
    output logic              weA,
    output logic              weB,
    output logic [ADDR_W-1:0] addrA,
    output logic [ADDR_W-1:0] addrB,
    output logic [DATA_W-1:0] dinA,
    output logic [DATA_W-1:0] dinB,
    input  logic [DATA_W-1:0] doutA,
    input  logic [DATA_W-1:0] doutB
);

    localparam int unsigned      CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_DRAIN = CNT_W'(DEPTH);

    bist_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr;
    logic              rd_vld, rd_phase;
    logic              mismatch, mis_phase;
    logic [ADDR_W-1:0] mis_addr;

    logic [7:0]        fail_cnt_q, fail_cnt_d;
    logic [ADDR_W-1:0] ffa_q, ffa_d;
    logic              ffp_q, ffp_d;
    logic              pass_q, pass_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) state_d = WR_A;
            end
            WR_A: if (cnt_q == CNT_LAST)  begin state_d = RD_B; cnt_d = '0; end
            RD_B: if (cnt_q == CNT_DRAIN) begin state_d = WR_B; cnt_d = '0; end
            WR_B: if (cnt_q == CNT_LAST)  begin state_d = RD_A; cnt_d = '0; end
            RD_A: if (cnt_q == CNT_DRAIN) begin state_d = FIN;  cnt_d = '0; end
            FIN: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        addr     = cnt_q[ADDR_W-1:0];
        busy     = (state_q != IDLE);
        done     = (state_q == FIN);
        weA      = 1'b0;
        weB      = 1'b0;
        addrA    = '0;
        addrB    = '0;
        dinA     = '0;
        dinB     = '0;
        rd_vld   = 1'b0;
        rd_phase = 1'b0;
        unique case (state_q)
            WR_A: begin
                weA   = 1'b1;
                addrA = addr;
                dinA  = DATA_W'(bist_pattern(16'(addr), 1'b0));
            end
            RD_B: if (cnt_q != CNT_DRAIN) begin
                addrB  = addr;
                rd_vld = 1'b1;
            end
            WR_B: begin
                weB   = 1'b1;
                addrB = addr;
                dinB  = DATA_W'(bist_pattern(16'(addr), 1'b1));
            end
            RD_A: if (cnt_q != CNT_DRAIN) begin
                addrA    = addr;
                rd_vld   = 1'b1;
                rd_phase = 1'b1;
            end
            default: ;
        endcase
    end

    tdp_bist_cmp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_cmp (
        .clk         (clk),
        .rst         (rst),
        .rd_vld_i    (rd_vld),
        .rd_phase_i  (rd_phase),
        .rd_addr_i   (addr),
        .doutA_i     (doutA),
        .doutB_i     (doutB),
        .mismatch_o  (mismatch),
        .mis_addr_o  (mis_addr),
        .mis_phase_o (mis_phase)
    );

    // The last compare lands on the RD_A->FIN edge, so pass uses the updated count.
    always_comb begin
        fail_cnt_d = fail_cnt_q;
        ffa_d      = ffa_q;
        ffp_d      = ffp_q;
        pass_d     = pass_q;
        if (state_q == IDLE && start) begin
            fail_cnt_d = '0;
            ffa_d      = '0;
            ffp_d      = 1'b0;
            pass_d     = 1'b0;
        end else if (mismatch) begin
            if (fail_cnt_q != 8'hFF) fail_cnt_d = fail_cnt_q + 8'd1;
            if (fail_cnt_q == 8'd0) begin
                ffa_d = mis_addr;
                ffp_d = mis_phase;
            end
        end
        if (state_q == RD_A && cnt_q == CNT_DRAIN) pass_d = (fail_cnt_d == 8'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fail_cnt_q <= '0;
            ffa_q      <= '0;
            ffp_q      <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            fail_cnt_q <= fail_cnt_d;
            ffa_q      <= ffa_d;
            ffp_q      <= ffp_d;
            pass_q     <= pass_d;
        end
    end

    always_comb begin
        fail_count       = fail_cnt_q;
        first_fail_addr  = ffa_q;
        first_fail_phase = ffp_q;
        pass             = pass_q;
    end

endmodule

// File: tb/tb_tdp_bist_ctrl.sv
// Self-checking bench for tdp_bist_ctrl: behavioural RAM with per-port read
// fault masks, and a result model derived from the fault configuration.
module tb_tdp_bist_ctrl;

    localparam int unsigned DW    = 256;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done, pass, first_fail_phase, weA, weB;
    logic [7:0]    fail_count;
    logic [AW-1:0] first_fail_addr, addrA, addrB;
    logic [DW-1:0] dinA, dinB, doutA, doutB;

    logic [DW-1:0] mem  [16];
    logic [DW-1:0] pre  [16];
    logic [DW-1:0] fA   [16];
    logic [DW-1:0] fB   [16];
    logic          zero_mode;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    tdp_bist_ctrl #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .fail_count       (fail_count),
        .first_fail_addr  (first_fail_addr),
        .first_fail_phase (first_fail_phase),
        .weA              (weA),
        .weB              (weB),
        .addrA            (addrA),
        .addrB            (addrB),
        .dinA             (dinA),
        .dinB             (dinB),
        .doutA            (doutA),
        .doutB            (doutB)
    );

    // RAM: synchronous write, one-cycle registered read with fault injection.
    always @(posedge clk) begin
        if (weA) mem[addrA] <= dinA;
        if (weB) mem[addrB] <= dinB;
        doutA <= zero_mode ? '0 : (mem[addrA] ^ fA[addrA]);
        doutB <= zero_mode ? '0 : (mem[addrB] ^ fB[addrB]);
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (weA === 1'b1 && weB === 1'b1) begin
            checks++;
            assert (1'b0) else begin
                errors++;
                $error("FAIL we_excl observed=both expected=one");
            end
        end
    end

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int a);
        logic [DW-1:0] p;
        p = {(DW/8){8'h55}};
        return p ^ DW'(a);
    endfunction

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Expected results: port-B readback of P(a), then port-A readback of ~P(a).
    task automatic ref_model(output int cnt, output int fa, output int fp, output bit ok);
        logic [DW-1:0] seen, want;
        cnt = 0; fa = 0; fp = 0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int a = 0; a < int'(DEPTH); a++) begin
                want = (ph == 0) ? pat(a) : ~pat(a);
                seen = zero_mode ? '0 : (want ^ ((ph == 0) ? fB[a] : fA[a]));
                if (seen != want) begin
                    if (cnt == 0) begin fa = a; fp = ph; end
                    if (cnt < 255) cnt++;
                end
            end
        end
        ok = (cnt == 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk_b({tag, "_busy"}, busy, 1'b0);
        chk_b({tag, "_done"}, done, 1'b0);
        chk_b({tag, "_pass"}, pass, 1'b0);
        chk_b({tag, "_weA"}, weA, 1'b0);
        chk_b({tag, "_weB"}, weB, 1'b0);
        chk_b({tag, "_ffp"}, first_fail_phase, 1'b0);
        chk_i({tag, "_fc"}, int'(fail_count), 0);
        chk_i({tag, "_ffa"}, int'(first_fail_addr), 0);
        chk_i({tag, "_addrA"}, int'(addrA), 0);
        chk_i({tag, "_addrB"}, int'(addrB), 0);
        chk_w({tag, "_dinA"}, dinA, '0);
        chk_w({tag, "_dinB"}, dinB, '0);
    endtask

    task automatic clear_faults();
        for (int a = 0; a < 16; a++) begin
            fA[a] = '0;
            fB[a] = '0;
        end
        zero_mode = 1'b0;
    endtask

    task automatic run_test(input string tag, input bit extra_starts, input int rst_at);
        int cyc, dc0, e_cnt, e_fa, e_fp;
        bit e_ok;
        dc0 = done_cnt;
        ref_model(e_cnt, e_fa, e_fp, e_ok);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1;
        chk_b({tag, "_busy_c1"}, busy, 1'b1);
        chk_i({tag, "_clr_fc"}, int'(fail_count), 0);
        chk_i({tag, "_clr_ffa"}, int'(first_fail_addr), 0);
        chk_b({tag, "_clr_pass"}, pass, 1'b0);
        while (done !== 1'b1 && cyc < 100) begin
            if (rst_at != 0 && cyc == rst_at) begin
                rst = 1'b1;
                @(negedge clk); rst = 1'b0;
                check_all_zero({tag, "_rst"});
                repeat (50) @(negedge clk);
                chk_i({tag, "_rst_nodone"}, done_cnt, dc0);
                chk_b({tag, "_rst_idle"}, busy, 1'b0);
                return;
            end
            start = (extra_starts && cyc == 5);
            @(negedge clk);
            cyc++;
            start = 1'b0;
        end
        chk_i({tag, "_len"}, cyc, 4 * int'(DEPTH) + 3);
        chk_b({tag, "_done"}, done, 1'b1);
        chk_b({tag, "_busy_fin"}, busy, 1'b1);
        chk_i({tag, "_fc"}, int'(fail_count), e_cnt);
        chk_i({tag, "_ffa"}, int'(first_fail_addr), e_fa);
        chk_b({tag, "_ffp"}, first_fail_phase, e_fp[0]);
        chk_b({tag, "_pass"}, pass, e_ok);
        start = extra_starts;
        @(negedge clk); start = 1'b0;
        chk_b({tag, "_busy_after"}, busy, 1'b0);
        chk_b({tag, "_done_after"}, done, 1'b0);
        chk_b({tag, "_pass_held"}, pass, e_ok);
        repeat (3) @(negedge clk);
        chk_b({tag, "_still_idle"}, busy, 1'b0);
        chk_i({tag, "_one_done"}, done_cnt, dc0 + 1);
        for (int a = 0; a < 16; a++) begin
            if (a < int'(DEPTH)) chk_w($sformatf("%s_mem%0d", tag, a), mem[a], ~pat(a));
            else                 chk_w($sformatf("%s_mem%0d", tag, a), mem[a], pre[a]);
        end
    endtask

    initial begin
        int n;
        int fa_sel;
        logic [DW-1:0] m;
        rst = 1'b1;
        start = 1'b0;
        clear_faults();
        for (int a = 0; a < 16; a++) begin
            pre[a] = rnd_word();
            mem[a] <= pre[a];
        end
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        run_test("healthy", 1'b0, 0);

        clear_faults();
        fB[3][0] = 1'b1;
        run_test("stuckB3", 1'b0, 0);

        clear_faults();
        fA[7] = rnd_word() | 256'd1;
        fA[2] = rnd_word() | 256'd2;
        fB[2] = rnd_word() | 256'd4;
        run_test("w7A_w2AB", 1'b0, 0);

        clear_faults();
        zero_mode = 1'b1;
        run_test("allzero", 1'b0, 0);

        clear_faults();
        run_test("extra_start", 1'b1, 0);

        fB[5] = 256'd1;
        run_test("rst_mid", 1'b0, 15);
        clear_faults();
        run_test("after_rst", 1'b0, 0);

        for (int t = 0; t < 6; t++) begin
            clear_faults();
            n = $urandom_range(0, 4);
            for (int k = 0; k < n; k++) begin
                fa_sel = $urandom_range(0, int'(DEPTH) - 1);
                m = rnd_word();
                m[$urandom_range(0, DW - 1)] = 1'b1;
                if ($urandom_range(0, 1) == 1) fA[fa_sel] = fA[fa_sel] ^ m;
                else                           fB[fa_sel] = fB[fa_sel] ^ m;
            end
            run_test($sformatf("rand%0d", t), 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
